// File: rtl/mem_load_sched_pkg.sv
// Shared types and sizing helpers for the memory-load handshake scheduler.
package mem_load_pkg;

   typedef enum logic [2:0] {IDLE, WAIT, GAP, RDY, FAIL} ld_state_e;

   localparam int unsigned DONE_WIN_DEF  = 5;
   localparam int unsigned RETRY_MAX_DEF = 2;

   function automatic int unsigned min1_clog2(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned id_width(input int unsigned n_req);
      return min1_clog2(n_req);
   endfunction

endpackage

// File: rtl/mem_load_sched_rr_pick.sv
// Round-robin search: first set req bit strictly after ptr, wrapping.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [IDW-1:0]   idx,
   output logic             valid
);

   int unsigned      pos;
   logic [IDW-1:0]   p;

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      pos   = 0;
      p     = '0;
      for (int unsigned off = 1; off <= N_REQ; off++) begin
         pos = (32'(ptr) + off) % N_REQ;
         p   = IDW'(pos);
         if (!valid && req[p]) begin
            idx   = p;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_load_sched.sv
// load_mem/done handshake controller: round-robin grant, bounded done window,
// retry on timeout, one-cycle ready or err completion pulse.
module mem_load_sched
   import mem_load_pkg::*;
#(
   parameter  int unsigned N_REQ     = 4,
   parameter  int unsigned DONE_WIN  = DONE_WIN_DEF,
   parameter  int unsigned RETRY_MAX = RETRY_MAX_DEF,
   localparam int unsigned IDW       = id_width(N_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             load_mem,
   input  logic             done,
   output logic             ready,
   output logic [IDW-1:0]   ready_id,
   output logic             err,
   output logic [IDW-1:0]   err_id,
   output logic             busy
);

   localparam int unsigned WIN_W = min1_clog2(DONE_WIN + 1);
   localparam int unsigned RET_W = min1_clog2(RETRY_MAX + 1);

   ld_state_e        state, state_nxt;
   logic [WIN_W-1:0] win_cnt, win_nxt;
   logic [RET_W-1:0] retry_cnt, retry_nxt;
   logic [IDW-1:0]   rr_ptr, ptr_nxt;
   logic [N_REQ-1:0] gnt_nxt;
   logic [IDW-1:0]   pick_idx;
   logic             pick_valid;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_rr_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // rr_ptr doubles as the grantee index for the whole transaction.
   always_comb begin
      state_nxt = state;
      win_nxt   = win_cnt;
      retry_nxt = retry_cnt;
      ptr_nxt   = rr_ptr;
      gnt_nxt   = '0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               ptr_nxt   = pick_idx;
               win_nxt   = '0;
               retry_nxt = '0;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (done) begin
               state_nxt = RDY;
            end else if (win_cnt == WIN_W'(DONE_WIN)) begin
               if (retry_cnt < RET_W'(RETRY_MAX)) begin
                  retry_nxt = retry_cnt + 1'b1;
                  state_nxt = GAP;
               end else begin
                  state_nxt = FAIL;
               end
            end else begin
               win_nxt = win_cnt + 1'b1;
            end
         end
         GAP: begin
            win_nxt   = '0;
            state_nxt = WAIT;
         end
         RDY, FAIL: state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
      if (state_nxt == WAIT || state_nxt == GAP) gnt_nxt[ptr_nxt] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         win_cnt   <= '0;
         retry_cnt <= '0;
         rr_ptr    <= IDW'(N_REQ - 1);
         gnt       <= '0;
         load_mem  <= 1'b0;
         ready     <= 1'b0;
         ready_id  <= '0;
         err       <= 1'b0;
         err_id    <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         win_cnt   <= win_nxt;
         retry_cnt <= retry_nxt;
         rr_ptr    <= ptr_nxt;
         gnt       <= gnt_nxt;
         load_mem  <= (state_nxt == WAIT);
         ready     <= (state_nxt == RDY);
         ready_id  <= (state_nxt == RDY) ? ptr_nxt : '0;
         err       <= (state_nxt == FAIL);
         err_id    <= (state_nxt == FAIL) ? ptr_nxt : '0;
         busy      <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_mem_load_sched.sv
// Directed bench for mem_load_sched with hand-computed expectations (N_REQ=4, DONE_WIN=5, RETRY_MAX=2).
module tb_mem_load_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       load_mem;
   logic       done;
   logic       ready;
   logic [1:0] ready_id;
   logic       err;
   logic [1:0] err_id;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   mem_load_sched #(
      .N_REQ     (4),
      .DONE_WIN  (5),
      .RETRY_MAX (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .gnt      (gnt),
      .load_mem (load_mem),
      .done     (done),
      .ready    (ready),
      .ready_id (ready_id),
      .err      (err),
      .err_id   (err_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Advance one cycle; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transaction from an IDLE cycle: done at offset off, expects grantee id.
   task automatic txn(input logic [3:0] r, input bit hold, input int off, input int id, input string tag);
      req = r;
      step();
      if (!hold) req = '0;
      chk({tag, ".gnt"}, 32'(gnt), 32'(1) << id);
      chk({tag, ".busy"}, 32'(busy), 1);
      for (int k = 0; k < off; k++) begin
         chk({tag, ".load_mem"}, 32'(load_mem), 1);
         step();
      end
      chk({tag, ".load_mem_last"}, 32'(load_mem), 1);
      done = 1'b1;
      step();
      done = 1'b0;
      chk({tag, ".ready"}, 32'(ready), 1);
      chk({tag, ".ready_id"}, 32'(ready_id), 32'(id));
      chk({tag, ".load_mem_rdy"}, 32'(load_mem), 0);
      chk({tag, ".gnt_rdy"}, 32'(gnt), 0);
      chk({tag, ".err"}, 32'(err), 0);
      step();
      chk({tag, ".ready_drop"}, 32'(ready), 0);
      chk({tag, ".busy_idle"}, 32'(busy), 0);
      chk({tag, ".load_mem_idle"}, 32'(load_mem), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      req   = '0;
      done  = 1'b0;
      do_reset();
      chk("rst.gnt", 32'(gnt), 0);
      chk("rst.load_mem", 32'(load_mem), 0);
      chk("rst.ready", 32'(ready), 0);
      chk("rst.err", 32'(err), 0);
      chk("rst.busy", 32'(busy), 0);

      // single load, done at offset 3 -> load_mem cycles 1..4, ready in cycle 5
      txn(4'b0001, 1'b0, 3, 0, "single");
      // zero-offset done: ready in the cycle right after the load_mem rise
      txn(4'b0010, 1'b0, 0, 1, "zero_off");

      // round robin from a fresh pointer, req held
      do_reset();
      txn(4'b1111, 1'b1, 2, 0, "rr0");
      txn(4'b1111, 1'b1, 2, 1, "rr1");
      txn(4'b1111, 1'b1, 2, 2, "rr2");
      txn(4'b1111, 1'b1, 2, 3, "rr3");
      txn(4'b1111, 1'b1, 2, 0, "rr4");
      req = '0;

      // retry then success: ptr=0, requester 1
      req = 4'b0010;
      step();
      req = '0;
      for (int k = 0; k <= 5; k++) begin
         chk("retry.win1", 32'(load_mem), 1);
         step();
      end
      chk("retry.gap_load", 32'(load_mem), 0);
      chk("retry.gap_gnt", 32'(gnt), 32'h2);
      chk("retry.gap_busy", 32'(busy), 1);
      step();
      chk("retry.win2_o0", 32'(load_mem), 1);
      step();
      chk("retry.win2_o1", 32'(load_mem), 1);
      step();
      chk("retry.win2_o2", 32'(load_mem), 1);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("retry.ready", 32'(ready), 1);
      chk("retry.ready_id", 32'(ready_id), 1);
      chk("retry.err", 32'(err), 0);
      step();

      // exhaustion: ptr=1, requester 2, done never comes
      req = 4'b0100;
      step();
      req = '0;
      for (int w = 0; w < 3; w++) begin
         for (int k = 0; k <= 5; k++) begin
            chk("exh.load_mem", 32'(load_mem), 1);
            chk("exh.gnt", 32'(gnt), 32'h4);
            step();
         end
         if (w < 2) begin
            chk("exh.gap_load", 32'(load_mem), 0);
            chk("exh.gap_err", 32'(err), 0);
            step();
         end
      end
      chk("exh.err", 32'(err), 1);
      chk("exh.err_id", 32'(err_id), 2);
      chk("exh.ready", 32'(ready), 0);
      chk("exh.gnt_fail", 32'(gnt), 0);
      step();
      chk("exh.err_drop", 32'(err), 0);
      chk("exh.busy", 32'(busy), 0);

      // reset mid-WAIT at offset 2 (ptr=2 -> requester 0)
      req = 4'b0001;
      step();
      req = '0;
      chk("rmid.gnt", 32'(gnt), 32'h1);
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rmid.gnt0", 32'(gnt), 0);
      chk("rmid.load0", 32'(load_mem), 0);
      chk("rmid.busy0", 32'(busy), 0);
      chk("rmid.ready0", 32'(ready), 0);
      chk("rmid.err0", 32'(err), 0);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("stray.busy", 32'(busy), 0);
      chk("stray.ready", 32'(ready), 0);
      step();
      chk("stray.ready2", 32'(ready), 0);
      chk("stray.load", 32'(load_mem), 0);
      // fresh pointer (3) must pick requester 0 ahead of 3
      txn(4'b1001, 1'b0, 1, 0, "ptr_reinit");
      // pointer now 0, so requester 3 wins next
      txn(4'b1000, 1'b0, 5, 3, "last_off");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
